// File: rtl/addr_cal_pkg.sv
// Shared sprite definitions: default widths, descriptor field positions and
// packed descriptor layouts used by addr_cal and the display modules.
package addr_cal_pkg;

    // Default widths for addresses/descriptor fields and screen coordinates.
    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned COORD_W_DEF = 10;

    // Pattern descriptor: five ADDR_W-wide slots, numbered from the LSB.
    localparam int unsigned PAT_SLOTS        = 5;
    localparam int unsigned PAT_BASE_SLOT    = 4;
    localparam int unsigned PAT_WIDTH_SLOT   = 3;
    localparam int unsigned PAT_HEIGHT_SLOT  = 2;
    localparam int unsigned PAT_STRIDE_SLOT  = 1;
    localparam int unsigned PAT_RSVD_SLOT    = 0;

    // Sprite descriptor: three COORD_W-wide slots plus two flag bits on top.
    localparam int unsigned SPR_COORD_SLOTS  = 3;
    localparam int unsigned SPR_X_SLOT       = 2;
    localparam int unsigned SPR_Y_SLOT       = 1;
    localparam int unsigned SPR_RSVD_SLOT    = 0;
    localparam int unsigned SPR_HFLIP_OFS    = 0;  // above the coordinate slots
    localparam int unsigned SPR_VISIBLE_OFS  = 1;  // above the coordinate slots

    // Pattern descriptor at default widths (80 bits).
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] base;
        logic [ADDR_W_DEF-1:0] width;
        logic [ADDR_W_DEF-1:0] height;
        logic [ADDR_W_DEF-1:0] stride;
        logic [ADDR_W_DEF-1:0] reserved;
    } pattern_info_t;

    // Sprite descriptor at default widths (32 bits).
    typedef struct packed {
        logic                   visible;
        logic                   hflip;
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic [COORD_W_DEF-1:0] reserved;
    } sprite_info_t;

endpackage

// File: rtl/addr_cal.sv
// Sprite address calculator: decides whether the current beam position lies
// on a visible sprite and, if so, which pattern-memory word it maps to.
// One register stage; outputs reflect inputs sampled at the previous edge.
module addr_cal
    import addr_cal_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned COORD_W = COORD_W_DEF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [PAT_SLOTS*ADDR_W-1:0]            pattern_info,
    input  logic [SPR_COORD_SLOTS*COORD_W+1:0]     sprite_info,
    input  logic [COORD_W-1:0]                     hcount,
    input  logic [COORD_W-1:0]                     vcount,
    output logic [ADDR_W-1:0]                      addr_output,
    output logic                                   valid
);

    // One bit wider than either operand so x+width / y+height never wrap.
    localparam int unsigned CMP_W = ((ADDR_W > COORD_W) ? ADDR_W : COORD_W) + 1;

    logic [ADDR_W-1:0]  base_c;
    logic [ADDR_W-1:0]  width_c;
    logic [ADDR_W-1:0]  height_c;
    logic [ADDR_W-1:0]  stride_c;
    logic [COORD_W-1:0] x_c;
    logic [COORD_W-1:0] y_c;
    logic               visible_c;
    logic               hflip_c;
    logic               unused_rsvd_c;

    logic [CMP_W-1:0]   h_ext_c;
    logic [CMP_W-1:0]   v_ext_c;
    logic [CMP_W-1:0]   x_ext_c;
    logic [CMP_W-1:0]   y_ext_c;
    logic [CMP_W-1:0]   x_end_c;
    logic [CMP_W-1:0]   y_end_c;
    logic               in_box_c;

    logic [ADDR_W-1:0]  dx_c;
    logic [ADDR_W-1:0]  col_c;
    logic [ADDR_W-1:0]  row_c;
    logic [ADDR_W-1:0]  row_ofs_c;
    logic [ADDR_W-1:0]  addr_c;
    logic               valid_next_c;
    logic [ADDR_W-1:0]  addr_next_c;

    // Descriptor field extraction.
    assign base_c    = pattern_info[PAT_BASE_SLOT*ADDR_W   +: ADDR_W];
    assign width_c   = pattern_info[PAT_WIDTH_SLOT*ADDR_W  +: ADDR_W];
    assign height_c  = pattern_info[PAT_HEIGHT_SLOT*ADDR_W +: ADDR_W];
    assign stride_c  = pattern_info[PAT_STRIDE_SLOT*ADDR_W +: ADDR_W];
    assign x_c       = sprite_info[SPR_X_SLOT*COORD_W +: COORD_W];
    assign y_c       = sprite_info[SPR_Y_SLOT*COORD_W +: COORD_W];
    assign hflip_c   = sprite_info[SPR_COORD_SLOTS*COORD_W + SPR_HFLIP_OFS];
    assign visible_c = sprite_info[SPR_COORD_SLOTS*COORD_W + SPR_VISIBLE_OFS];

    // Reserved descriptor bits carry no meaning here.
    assign unused_rsvd_c = ^{pattern_info[PAT_RSVD_SLOT*ADDR_W +: ADDR_W],
                             sprite_info[SPR_RSVD_SLOT*COORD_W +: COORD_W]};

    // In-box test on widened operands; zero width/height yields an empty box.
    always_comb begin
        h_ext_c  = CMP_W'(hcount);
        v_ext_c  = CMP_W'(vcount);
        x_ext_c  = CMP_W'(x_c);
        y_ext_c  = CMP_W'(y_c);
        x_end_c  = x_ext_c + CMP_W'(width_c);
        y_end_c  = y_ext_c + CMP_W'(height_c);
        in_box_c = (h_ext_c >= x_ext_c) && (h_ext_c < x_end_c) &&
                   (v_ext_c >= y_ext_c) && (v_ext_c < y_end_c);
    end

    // Address: base + row*stride + col, wrapping modulo 2^ADDR_W.
    always_comb begin
        dx_c      = ADDR_W'(hcount - x_c);
        col_c     = hflip_c ? (width_c - ADDR_W'(1) - dx_c) : dx_c;
        row_c     = ADDR_W'(vcount - y_c);
        row_ofs_c = row_c * stride_c;
        addr_c    = base_c + row_ofs_c + col_c;
    end

    // Off-sprite pixels always present a zero address.
    always_comb begin
        valid_next_c = visible_c & in_box_c;
        addr_next_c  = valid_next_c ? addr_c : '0;
    end

    // Output register stage with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_output <= '0;
            valid       <= 1'b0;
        end else begin
            addr_output <= addr_next_c;
            valid       <= valid_next_c;
        end
    end

endmodule

// File: tb/tb_addr_cal.sv
// Directed bench for addr_cal: hand-computed vectors covering hits, flips,
// box edges, coordinate overflow, degenerate sizes, address wrap and reset.
module tb_addr_cal;
    import addr_cal_pkg::*;

    logic                   clk;
    logic                   reset;
    pattern_info_t          pat;
    sprite_info_t           spr;
    logic [COORD_W_DEF-1:0] hcount;
    logic [COORD_W_DEF-1:0] vcount;
    logic [ADDR_W_DEF-1:0]  addr_output;
    logic                   valid;

    int n_checks = 0;
    int n_pass   = 0;

    addr_cal #(
        .ADDR_W  (ADDR_W_DEF),
        .COORD_W (COORD_W_DEF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pattern_info (pat),
        .sprite_info  (spr),
        .hcount       (hcount),
        .vcount       (vcount),
        .addr_output  (addr_output),
        .valid        (valid)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Program a sprite descriptor pair and the beam position.
    task automatic setup(input logic [15:0] base, input logic [15:0] w, input logic [15:0] h,
                         input logic [15:0] stride, input logic vis, input logic hf,
                         input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] hc, input logic [9:0] vc);
        pat.base     = base;
        pat.width    = w;
        pat.height   = h;
        pat.stride   = stride;
        pat.reserved = 16'h0000;
        spr.visible  = vis;
        spr.hflip    = hf;
        spr.x        = x;
        spr.y        = y;
        spr.reserved = 10'h000;
        hcount       = hc;
        vcount       = vc;
    endtask

    // Wait one edge, then sample outputs just after it.
    task automatic step_check(input string tag, input logic exp_v, input logic [15:0] exp_a);
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(valid), 32'(exp_v));
        check({tag, ".addr"}, 32'(addr_output), 32'(exp_a));
    endtask

    initial begin
        reset = 1'b1;
        setup(16'd0, 16'd16, 16'd16, 16'd16, 1'b1, 1'b0, 10'd100, 10'd50, 10'd105, 10'd53);
        #12;
        check("reset.valid", 32'(valid), 32'd0);
        check("reset.addr", 32'(addr_output), 32'd0);

        // Release between edges; first edge uses the current inputs.
        reset = 1'b0;
        step_check("hit", 1'b1, 16'd53);

        // Horizontal flip: dx=0 maps to col 15.
        setup(16'd256, 16'd16, 16'd16, 16'd16, 1'b1, 1'b1, 10'd100, 10'd50, 10'd100, 10'd50);
        step_check("hflip", 1'b1, 16'd271);

        // Box edges: one past right / bottom, last pixel inside, one before left / top.
        setup(16'd0, 16'd16, 16'd16, 16'd16, 1'b1, 1'b0, 10'd100, 10'd50, 10'd116, 10'd53);
        step_check("edge_right", 1'b0, 16'd0);
        setup(16'd0, 16'd16, 16'd16, 16'd16, 1'b1, 1'b0, 10'd100, 10'd50, 10'd105, 10'd66);
        step_check("edge_bottom", 1'b0, 16'd0);
        setup(16'd0, 16'd16, 16'd16, 16'd16, 1'b1, 1'b0, 10'd100, 10'd50, 10'd115, 10'd65);
        step_check("edge_last", 1'b1, 16'd255);
        setup(16'd0, 16'd16, 16'd16, 16'd16, 1'b1, 1'b0, 10'd100, 10'd50, 10'd99, 10'd53);
        step_check("edge_left", 1'b0, 16'd0);
        setup(16'd0, 16'd16, 16'd16, 16'd16, 1'b1, 1'b0, 10'd100, 10'd50, 10'd105, 10'd49);
        step_check("edge_top", 1'b0, 16'd0);

        // Invisible sprite over an in-box pixel.
        setup(16'd0, 16'd16, 16'd16, 16'd16, 1'b0, 1'b0, 10'd100, 10'd50, 10'd105, 10'd53);
        step_check("invisible", 1'b0, 16'd0);

        // Sprite running off the right screen edge: x+width exceeds 10 bits.
        setup(16'd0, 16'd16, 16'd16, 16'd16, 1'b1, 1'b0, 10'd1020, 10'd50, 10'd1023, 10'd50);
        step_check("ovf_in", 1'b1, 16'd3);
        setup(16'd0, 16'd16, 16'd16, 16'd16, 1'b1, 1'b0, 10'd1020, 10'd50, 10'd5, 10'd50);
        step_check("ovf_wrapcol", 1'b0, 16'd0);

        // Degenerate sizes.
        setup(16'd0, 16'd0, 16'd16, 16'd16, 1'b1, 1'b0, 10'd100, 10'd50, 10'd100, 10'd50);
        step_check("zero_w", 1'b0, 16'd0);
        setup(16'd0, 16'd16, 16'd0, 16'd16, 1'b1, 1'b0, 10'd100, 10'd50, 10'd100, 10'd50);
        step_check("zero_h", 1'b0, 16'd0);

        // Zero stride aliases every row to row 0.
        setup(16'd0, 16'd16, 16'd16, 16'd0, 1'b1, 1'b0, 10'd100, 10'd50, 10'd105, 10'd60);
        step_check("zero_stride", 1'b1, 16'd5);

        // Address wrap: base near top, and row*stride beyond 16 bits.
        setup(16'hFFF0, 16'd16, 16'd16, 16'd16, 1'b1, 1'b0, 10'd100, 10'd50, 10'd105, 10'd50);
        step_check("wrap_base", 1'b1, 16'hFFF5);
        setup(16'd0, 16'd16, 16'd32, 16'h1000, 1'b1, 1'b0, 10'd100, 10'd50, 10'd105, 10'd70);
        step_check("wrap_mul", 1'b1, 16'd16389);

        // Reserved bits are ignored.
        setup(16'd0, 16'd16, 16'd16, 16'd16, 1'b1, 1'b0, 10'd100, 10'd50, 10'd105, 10'd53);
        pat.reserved = 16'hFFFF;
        spr.reserved = 10'h3FF;
        step_check("reserved", 1'b1, 16'd53);

        // Latency: an input change between edges does not reach the outputs.
        setup(16'd0, 16'd16, 16'd16, 16'd16, 1'b1, 1'b0, 10'd100, 10'd50, 10'd0, 10'd0);
        #3;
        check("hold.valid", 32'(valid), 32'd1);
        check("hold.addr", 32'(addr_output), 32'd53);
        step_check("hold_next", 1'b0, 16'd0);

        // Reset mid-frame clears outputs with no clock edge.
        setup(16'd0, 16'd16, 16'd16, 16'd16, 1'b1, 1'b0, 10'd100, 10'd50, 10'd110, 10'd52);
        step_check("pre_rst", 1'b1, 16'd42);
        reset = 1'b1;
        #1;
        check("midrst.valid", 32'(valid), 32'd0);
        check("midrst.addr", 32'(addr_output), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        step_check("post_rst", 1'b1, 16'd42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/addr_cal.md
ADDR_CAL -- requirements
Module: addr_cal

Interface
- REQ-001 Parameter ADDR_W, default 16: width of addr_output and of every pattern_info field.
- REQ-002 Parameter COORD_W, default 10: width of hcount, vcount and the sprite coordinates.
- REQ-003 Clocking: one clock; reset is asynchronous and active-high.
- REQ-004 Port clk, input, 1: rising-edge clock.
- REQ-005 Port reset, input, 1: asynchronous active-high reset.
- REQ-006 Port pattern_info, input, 80: {base[79:64], width[63:48], height[47:32], stride[31:16], reserved[15:0]}.
- REQ-007 Port sprite_info, input, 32: {visible[31], hflip[30], x[29:20], y[19:10], reserved[9:0]}.
- REQ-008 Port hcount, input, 10: current pixel column.
- REQ-009 Port vcount, input, 10: current pixel row.
- REQ-010 Port addr_output, output, 16: sprite memory address of the current pixel.
- REQ-011 Port valid, output, 1: high when the current pixel lies on a visible sprite.

Function
- REQ-012 In-box test: hcount >= x and hcount < x+width, and vcount >= y and vcount < y+height.
- REQ-013 Compare width: all sums and compares are at least 17 bits wide, so x+width and y+height never wrap.
- REQ-014 Column offset: dx = hcount-x; col = hflip ? (width-1-dx) : dx.
- REQ-015 Row offset: row = vcount-y.
- REQ-016 Address: addr = base + row*stride + col, truncated to 16 bits (modulo 2^16 wrap).
- REQ-017 Valid: valid_next = visible AND in-box.
- REQ-018 Address when not valid: addr_next = 0 whenever valid_next = 0.
- REQ-019 Latency: addr_output and valid are registered and reflect the inputs sampled at the previous rising clk edge (1-cycle latency).
- REQ-020 Input timing: all inputs are sampled every cycle; no handshake; input changes take effect on the next edge.
- REQ-021 Zero size: width = 0 or height = 0 gives valid = 0 for all pixels.
- REQ-022 Zero stride: stride = 0 makes all rows alias row 0; this is legal and needs no special case.
- REQ-023 Reserved fields: reserved bits are ignored.
- REQ-024 Screen edge: a sprite partly off-screen is clipped naturally; a pixel counts only when hcount/vcount actually falls inside the box.

Reset
- REQ-025 Reset values: while reset = 1, addr_output = 0 and valid = 0, asynchronously.
- REQ-026 Reset mid-operation: asserting reset mid-frame clears the outputs immediately.
- REQ-027 Reset release: the first rising edge after release produces outputs from the current inputs.

Structure
- REQ-028 Shared package: field bit positions (base, width, height, stride, visible, hflip, x, y) and ADDR_W/COORD_W defaults go in a shared sprite package used by addr_cal and by the display modules.
- REQ-029 Module layout: addr_cal is a single module with combinational in-box and address logic feeding one output register stage; no sub-module is required.
- REQ-030 Multiplier: the row*stride multiply is inferred combinationally, 16x16 truncated to 16 bits.

Verification
- REQ-031 Scenario, normal hit: base=0, w=h=16, stride=16, visible=1, hflip=0, x=100, y=50, hcount=105, vcount=53 -> next cycle valid=1, addr=53.
- REQ-032 Scenario, hflip: same sprite with hflip=1, hcount=100, vcount=50, base=256 -> valid=1, addr=271.
- REQ-033 Scenario, box edges: hcount=116 or vcount=66 -> valid=0, addr=0; hcount=115, vcount=65 -> valid=1, addr=255.
- REQ-034 Scenario, invisible: visible=0 with an in-box pixel -> valid=0, addr=0.
- REQ-035 Scenario, overflow edge: x=1020, w=16, hcount=1023 -> valid=1, col=3 (no wrap of x+width).
- REQ-036 Scenario, reset: assert reset between edges while valid=1 -> valid=0 and addr=0 without a clock edge; after release, outputs track inputs after 1 edge.
